fault_event_tracker: RTL

FAULT_EVENT_TRACKER -- requirements
Module: fault_event_tracker

---
 rtl/fault_tracker_pkg.sv | 23 ++
 rtl/fault_debounce.sv | 61 ++++++
 rtl/fault_event_tracker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fault_tracker_pkg.sv
// rtl/fault_tracker_pkg.sv - shared zone/fault state types and parameter defaults for the fault event tracker
package fault_tracker_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int EU_LAST_NODE_DEFAULT    = 8;
    localparam int CU_LAST_NODE_DEFAULT    = 16;
    localparam int FINAL_NODE_DEFAULT      = 30;
    localparam int NODE_COUNT_W            = 6;

    typedef enum logic [1:0] {
        EU   = 2'd0,
        CU   = 2'd1,
        RU   = 2'd2,
        DONE = 2'd3
    } zone_t;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        FAULT_SEEN = 2'd1,
        CARRY      = 2'd2
    } fault_state_t;

endpackage

// File: rtl/fault_debounce.sv
// rtl/fault_debounce.sv - 2-FF sensor synchronizer plus confirm pulse; FAULT_DEBOUNCE_EN selects stable-high debounce
module fault_debounce
    import fault_tracker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic fault_sensor,
    output logic confirm
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= fault_sensor;
            sync_q2 <= sync_q1;
        end
    end

`ifdef FAULT_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;

    // Counter saturates at CNT_MAX so a sensor held high confirms only once.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            stable_cnt <= '0;
            confirm    <= 1'b0;
        end else begin
            confirm <= sync_q2 && (stable_cnt == CNT_LAST);
            if (!sync_q2) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic sync_prev;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            sync_prev <= 1'b0;
            confirm   <= 1'b0;
        end else begin
            sync_prev <= sync_q2;
            confirm   <= sync_q2 && !sync_prev;
        end
    end
`endif

endmodule

// File: rtl/fault_event_tracker.sv
// rtl/fault_event_tracker.sv - node counter, zone FSM and fault/pick/drop FSM; FAULT_DEBOUNCE_EN enables debounce
module fault_event_tracker
    import fault_tracker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int EU_LAST_NODE    = EU_LAST_NODE_DEFAULT,
    parameter int CU_LAST_NODE    = CU_LAST_NODE_DEFAULT,
    parameter int FINAL_NODE      = FINAL_NODE_DEFAULT
) (
    input  logic                    clk_50M,
    input  logic                    reset,
    input  logic                    node_flag,
    input  logic                    fault_sensor,
    input  logic                    block_picked,
    input  logic                    block_dropped,
    output logic                    EU_fault_flag,
    output logic                    CU_fault_flag,
    output logic                    RU_fault_flag,
    output logic                    fault_detect,
    output logic                    object_drop,
    output logic                    run_complete,
    output logic [NODE_COUNT_W-1:0] node_count
);

    localparam logic [NODE_COUNT_W-1:0] EU_LAST = NODE_COUNT_W'(EU_LAST_NODE);
    localparam logic [NODE_COUNT_W-1:0] CU_LAST = NODE_COUNT_W'(CU_LAST_NODE);
    localparam logic [NODE_COUNT_W-1:0] FINAL   = NODE_COUNT_W'(FINAL_NODE);

    logic fault_confirm;

    fault_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .fault_sensor(fault_sensor),
        .confirm     (fault_confirm)
    );

    zone_t        zone_q, zone_d;
    fault_state_t fstate_q, fstate_d;
    logic [2:0]   reported_q;
    logic         zone_reported;
    logic         fault_accept;
    logic         drop_accept;
    logic         rc_sent;
    logic         rc_fire;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            node_count <= '0;
        end else if (node_flag && zone_q != DONE && node_count != FINAL) begin
            node_count <= node_count + NODE_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            zone_q <= EU;
        end else begin
            zone_q <= zone_d;
        end
    end

    // Zone trails node_count by one cycle, so a same-cycle node_flag cannot re-attribute a fault.
    always_comb begin
        zone_d = zone_q;
        case (zone_q)
            EU:      if (node_count > EU_LAST) zone_d = CU;
            CU:      if (node_count > CU_LAST) zone_d = RU;
            RU:      if (node_count >= FINAL)  zone_d = DONE;
            DONE:    zone_d = DONE;
            default: zone_d = EU;
        endcase
    end

    always_comb begin
        zone_reported = 1'b1;
        case (zone_q)
            EU:      zone_reported = reported_q[0];
            CU:      zone_reported = reported_q[1];
            RU:      zone_reported = reported_q[2];
            default: zone_reported = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            fstate_q <= SCAN;
        end else begin
            fstate_q <= fstate_d;
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        case (fstate_q)
            SCAN:       if (fault_confirm && !zone_reported) fstate_d = FAULT_SEEN;
            FAULT_SEEN: if (block_picked)                    fstate_d = CARRY;
            CARRY:      if (block_dropped)                   fstate_d = SCAN;
            default:    fstate_d = SCAN;
        endcase
    end

    always_comb begin
        fault_detect = (fstate_q == FAULT_SEEN);
        fault_accept = (fstate_q == SCAN) && fault_confirm && !zone_reported;
        drop_accept  = (fstate_q == CARRY) && block_dropped;
        rc_fire      = (fstate_q == SCAN) && (node_count == FINAL) && !rc_sent;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            EU_fault_flag <= 1'b0;
            CU_fault_flag <= 1'b0;
            RU_fault_flag <= 1'b0;
            object_drop   <= 1'b0;
            run_complete  <= 1'b0;
            reported_q    <= 3'b000;
            rc_sent       <= 1'b0;
        end else begin
            EU_fault_flag <= fault_accept && (zone_q == EU);
            CU_fault_flag <= fault_accept && (zone_q == CU);
            RU_fault_flag <= fault_accept && (zone_q == RU);
            object_drop   <= drop_accept;
            run_complete  <= rc_fire;
            reported_q    <= reported_q | {fault_accept && (zone_q == RU),
                                           fault_accept && (zone_q == CU),
                                           fault_accept && (zone_q == EU)};
            if (rc_fire) begin
                rc_sent <= 1'b1;
            end
        end
    end

endmodule
